blob_centroid: RTL and testbench

BLOB_CENTROID -- requirements
Module: blob_centroid

---
 rtl/blob_pkg.sv | 11 +
 rtl/blob_centroid_if.sv | 33 +++
 rtl/seq_divider.sv | 45 ++++
 rtl/blob_centroid.sv | 121 ++++++++++++
 tb/tb_blob_centroid.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/blob_pkg.sv
// blob_pkg: shared widths, divider iteration count and FSM states for blob_centroid.
package blob_pkg;
    localparam int DEF_X_W   = 11;
    localparam int DEF_Y_W   = 10;
    localparam int DEF_CNT_W = DEF_X_W + DEF_Y_W + 1;
    localparam int DEF_SX_W  = 2 * DEF_X_W + DEF_Y_W + 1;
    localparam int DEF_SY_W  = DEF_X_W + 2 * DEF_Y_W + 1;
    localparam int DIV_ITER  = 33;
    localparam int DIV_CNT_W = $clog2(DIV_ITER + 1);
    typedef enum logic [1:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_DONE} state_e;
endpackage

// File: rtl/blob_centroid_if.sv
// blob_centroid_if: pixel-stream/result bundle and the divider start/busy/done handshake.
interface blob_centroid_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic               fval;
    logic               dval;
    logic               wb;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               odval;
    logic               ofound;
    logic               ooverrun;
    logic [X_W-1:0]     ox;
    logic [Y_W-1:0]     oy;
    logic [X_W+Y_W:0]   ocount;
    modport master(output fval, dval, wb, x, y, input odval, ofound, ooverrun, ox, oy, ocount);
    modport slave(input fval, dval, wb, x, y, output odval, ofound, ooverrun, ox, oy, ocount);
endinterface

interface blob_div_if #(
    parameter int DW = 33,
    parameter int CW = 22
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [CW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    modport master(output start, dividend, divisor, input busy, done, quotient);
    modport slave(input start, dividend, divisor, output busy, done, quotient);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per cycle for DIV_ITER cycles.
// The start edge performs the first step; done marks the edge of the final step.
module seq_divider
    import blob_pkg::*;
#(
    parameter int DW = DIV_ITER,
    parameter int CW = DEF_CNT_W
) (
    input logic       clk,
    input logic       rst,
    blob_div_if.slave d
);
    logic [CW-1:0]        rem_q, rem_s, rem_d;
    logic [DW-1:0]        quo_q, quo_s, quo_d;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [CW:0]          trial;
    logic                 ge;
    logic                 busy;

    always_comb begin
        rem_s = d.start ? '0 : rem_q;
        quo_s = d.start ? d.dividend : quo_q;
        trial = {rem_s, quo_s[DW-1]};
        ge    = trial >= {1'b0, d.divisor};
        rem_d = ge ? CW'(trial - {1'b0, d.divisor}) : trial[CW-1:0];
        quo_d = {quo_s[DW-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (d.start || busy) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= d.start ? DIV_CNT_W'(DIV_ITER - 1) : cnt_q - 1'b1;
        end
    end

    assign busy       = cnt_q != '0;
    assign d.busy     = busy;
    assign d.done     = cnt_q == DIV_CNT_W'(1);
    assign d.quotient = quo_q;
endmodule

// File: rtl/blob_centroid.sv
// blob_centroid: per-frame marked-pixel count and centroid via a shared sequential divider.
// Define BLOB_CENTROID_ROI_EN to restrict counting to an inclusive rectangular ROI.
module blob_centroid
    import blob_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int MIN_PIXELS = 64
`ifdef BLOB_CENTROID_ROI_EN
    ,
    parameter int ROI_X0     = 0,
    parameter int ROI_X1     = 2047,
    parameter int ROI_Y0     = 0,
    parameter int ROI_Y1     = 1023
`endif
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic             iWB,
    input  logic [X_W-1:0]   iX_Cont,
    input  logic [Y_W-1:0]   iY_Cont,
    output logic             oDVAL,
    output logic [X_W-1:0]   oDATA_x,
    output logic [Y_W-1:0]   oDATA_y,
    output logic             oFOUND,
    output logic [X_W+Y_W:0] oCOUNT,
    output logic             oOVERRUN
);
    localparam int CNT_W = X_W + Y_W + 1;
    localparam int SX_W  = 2 * X_W + Y_W + 1;
    localparam int SY_W  = X_W + 2 * Y_W + 1;
    localparam int DW    = DIV_ITER;

    state_e           state_q;
    logic             fval_q, rise, fall, in_roi, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_op_q;
    logic [SX_W-1:0]  sx_q, sx_d, sx_op_q;
    logic [SY_W-1:0]  sy_q, sy_d, sy_op_q;
    logic             found_op_q;
    logic [X_W-1:0]   qx_q;

    blob_div_if #(.DW(DW), .CW(CNT_W)) div ();
    seq_divider #(.DW(DW), .CW(CNT_W)) u_div (.clk(iCLK), .rst(iRST), .d(div));

`ifdef BLOB_CENTROID_ROI_EN
    assign in_roi = int'(iX_Cont) >= ROI_X0 && int'(iX_Cont) <= ROI_X1 &&
                    int'(iY_Cont) >= ROI_Y0 && int'(iY_Cont) <= ROI_Y1;
`else
    assign in_roi = 1'b1;
`endif

    assign rise = iFVAL & ~fval_q;
    assign fall = ~iFVAL & fval_q;
    assign hit  = iFVAL & iDVAL & iWB & in_roi;

    always_comb begin
        cnt_d = (rise ? '0 : cnt_q) + CNT_W'(hit);
        sx_d  = (rise ? '0 : sx_q) + (hit ? SX_W'(iX_Cont) : '0);
        sy_d  = (rise ? '0 : sy_q) + (hit ? SY_W'(iY_Cont) : '0);
    end

    // Empty frames divide by 1 and discard the result, so the strobe timing never changes.
    assign div.start    = (state_q == S_DIV_X || state_q == S_DIV_Y) && !div.busy;
    assign div.dividend = state_q == S_DIV_X ? DW'(sx_op_q) : DW'(sy_op_q);
    assign div.divisor  = cnt_op_q == '0 ? CNT_W'(1) : cnt_op_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            fval_q     <= 1'b0;
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            cnt_op_q   <= '0;
            sx_op_q    <= '0;
            sy_op_q    <= '0;
            found_op_q <= 1'b0;
            qx_q       <= '0;
            oDVAL      <= 1'b0;
            oDATA_x    <= '0;
            oDATA_y    <= '0;
            oFOUND     <= 1'b0;
            oCOUNT     <= '0;
            oOVERRUN   <= 1'b0;
        end else begin
            fval_q <= iFVAL;
            cnt_q  <= cnt_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            oDVAL  <= 1'b0;
            if (fall && state_q != S_IDLE)
                oOVERRUN <= 1'b1;
            case (state_q)
                S_IDLE: if (fall) begin
                    cnt_op_q   <= cnt_q;
                    sx_op_q    <= sx_q;
                    sy_op_q    <= sy_q;
                    found_op_q <= cnt_q >= CNT_W'(MIN_PIXELS);
                    state_q    <= S_DIV_X;
                end
                S_DIV_X: if (div.done) state_q <= S_DIV_Y;
                S_DIV_Y: begin
                    if (div.start) qx_q <= div.quotient[X_W-1:0];
                    if (div.done) state_q <= S_DONE;
                end
                default: begin
                    oDVAL   <= 1'b1;
                    oCOUNT  <= cnt_op_q;
                    oFOUND  <= found_op_q;
                    if (found_op_q) begin
                        oDATA_x <= qx_q;
                        oDATA_y <= div.quotient[Y_W-1:0];
                    end
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_blob_centroid.sv
// tb_blob_centroid: table, hand-written and random frames against an arithmetic centroid model.
module tb_blob_centroid;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blob_centroid_if #(.X_W(11), .Y_W(10)) bus ();

    logic        d1_dval, d1_found, d1_ovr;
    logic [10:0] d1_x;
    logic [9:0]  d1_y;
    logic [21:0] d1_cnt;

    blob_centroid #(.MIN_PIXELS(16)) dut (
        .iCLK(clk), .iRST(rst), .iFVAL(bus.fval), .iDVAL(bus.dval), .iWB(bus.wb),
        .iX_Cont(bus.x), .iY_Cont(bus.y), .oDVAL(bus.odval), .oDATA_x(bus.ox),
        .oDATA_y(bus.oy), .oFOUND(bus.ofound), .oCOUNT(bus.ocount), .oOVERRUN(bus.ooverrun));

    blob_centroid #(.MIN_PIXELS(1)) dut1 (
        .iCLK(clk), .iRST(rst), .iFVAL(bus.fval), .iDVAL(bus.dval), .iWB(bus.wb),
        .iX_Cont(bus.x), .iY_Cont(bus.y), .oDVAL(d1_dval), .oDATA_x(d1_x),
        .oDATA_y(d1_y), .oFOUND(d1_found), .oCOUNT(d1_cnt), .oOVERRUN(d1_ovr));

`ifdef BLOB_CENTROID_ROI_EN
    logic        r_dval, r_found, r_ovr;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [21:0] r_cnt;
    blob_centroid #(.MIN_PIXELS(1), .ROI_X0(200), .ROI_X1(300)) dut_roi (
        .iCLK(clk), .iRST(rst), .iFVAL(bus.fval), .iDVAL(bus.dval), .iWB(bus.wb),
        .iX_Cont(bus.x), .iY_Cont(bus.y), .oDVAL(r_dval), .oDATA_x(r_x),
        .oDATA_y(r_y), .oFOUND(r_found), .oCOUNT(r_cnt), .oOVERRUN(r_ovr));
    int rx = 0, ry = 0;
`endif

    typedef struct {int x0, y0, w, h, ex, ey, ec, ef;} vec_t;
    vec_t tbl[5];
    int total = 0, bad = 0;
    int hx[$], hy[$];
    int mx = 0, my = 0, ax = 0, ay = 0;

    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Centroid from the frame's hit list using plain integer arithmetic.
    task automatic model(input int minp, input int x0, input int x1, input int y0, input int y1,
                         inout int px, inout int py, output int ec, output int ef);
        longint c = 0, sx = 0, sy = 0;
        foreach (hx[i])
            if (hx[i] >= x0 && hx[i] <= x1 && hy[i] >= y0 && hy[i] <= y1) begin
                c++;
                sx += hx[i];
                sy += hy[i];
            end
        ec = int'(c);
        ef = (c >= minp) ? 1 : 0;
        if (ef == 1) begin
            px = int'(sx / c);
            py = int'(sy / c);
        end
    endtask

    task automatic drive(input bit f, input bit d, input bit w, input int x, input int y);
        bus.fval = f;
        bus.dval = d;
        bus.wb   = w;
        bus.x    = 11'(x);
        bus.y    = 10'(y);
    endtask

    task automatic junk();
        drive(1'b0, 1'b1, 1'b1, $urandom_range(0, 2047), $urandom_range(0, 1023));
    endtask

    task automatic fill_block(input int x0, input int y0, input int w, input int h);
        hx.delete();
        hy.delete();
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                hx.push_back(x0 + i);
                hy.push_back(y0 + j);
            end
    endtask

    // First hit lands on the FVAL rise edge; the last call leaves FVAL low before E0.
    task automatic send_frame();
        bit b;
        if (hx.size() == 0) begin
            drive(1'b1, 1'b0, 1'b1, 5, 5);
            @(negedge clk);
        end
        foreach (hx[i]) begin
            drive(1'b1, 1'b1, 1'b1, hx[i], hy[i]);
            @(negedge clk);
            b = 1'($urandom_range(0, 1));
            drive(1'b1, b, !b, $urandom_range(0, 2047), $urandom_range(0, 1023));
            @(negedge clk);
        end
        junk();
    endtask

    task automatic wait_result(output int k, output int p, output int p1);
        k = 0;
        p = 0;
        p1 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.odval) begin
                p++;
                if (k == 0) k = i;
            end
            if (d1_dval) p1++;
            junk();
        end
    endtask

    task automatic check_frame(input string n, input int k, input int p, input int p1);
        int c, f;
        chk({n, ".lat"}, k, 68);
        chk({n, ".pulses"}, p, 1);
        chk({n, ".d1_pulses"}, p1, 1);
        model(16, 0, 2047, 0, 1023, mx, my, c, f);
        chk({n, ".cnt"}, bus.ocount, c);
        chk({n, ".found"}, bus.ofound, f);
        chk({n, ".x"}, bus.ox, mx);
        chk({n, ".y"}, bus.oy, my);
        model(1, 0, 2047, 0, 1023, ax, ay, c, f);
        chk({n, ".d1_cnt"}, d1_cnt, c);
        chk({n, ".d1_found"}, d1_found, f);
        chk({n, ".d1_x"}, d1_x, ax);
        chk({n, ".d1_y"}, d1_y, ay);
`ifdef BLOB_CENTROID_ROI_EN
        model(1, 200, 300, 0, 1023, rx, ry, c, f);
        chk({n, ".roi_cnt"}, r_cnt, c);
        chk({n, ".roi_x"}, r_x, rx);
        chk({n, ".roi_y"}, r_y, ry);
`endif
    endtask

    task automatic chk_zero(input string n);
        chk({n, ".dval"}, bus.odval, 0);
        chk({n, ".x"}, bus.ox, 0);
        chk({n, ".y"}, bus.oy, 0);
        chk({n, ".found"}, bus.ofound, 0);
        chk({n, ".cnt"}, bus.ocount, 0);
        chk({n, ".ovr"}, bus.ooverrun, 0);
    endtask

    initial begin
        int k, p, p1, n;
        tbl[0] = '{100, 50, 4, 4, 101, 51, 16, 1};
        tbl[1] = '{0, 0, 0, 0, 101, 51, 0, 0};
        tbl[2] = '{10, 20, 2, 2, 101, 51, 4, 0};
        tbl[3] = '{200, 300, 8, 2, 203, 300, 16, 1};
        tbl[4] = '{2040, 1016, 8, 8, 2043, 1019, 64, 1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            fill_block(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h);
            send_frame();
            wait_result(k, p, p1);
            check_frame($sformatf("tbl%0d", i), k, p, p1);
            chk($sformatf("tbl%0d.const_x", i), bus.ox, tbl[i].ex);
            chk($sformatf("tbl%0d.const_y", i), bus.oy, tbl[i].ey);
            chk($sformatf("tbl%0d.const_cnt", i), bus.ocount, tbl[i].ec);
            chk($sformatf("tbl%0d.const_found", i), bus.ofound, tbl[i].ef);
        end

        hx = '{0, 2047};
        hy = '{0, 1023};
        send_frame();
        wait_result(k, p, p1);
        check_frame("corners", k, p, p1);
        chk("corners.const_x", d1_x, 1023);
        chk("corners.const_y", d1_y, 511);

`ifdef BLOB_CENTROID_ROI_EN
        hx = '{150, 250};
        hy = '{10, 10};
        send_frame();
        wait_result(k, p, p1);
        check_frame("roi", k, p, p1);
        chk("roi.const_cnt", r_cnt, 1);
        chk("roi.const_x", r_x, 250);
`endif

        // Second frame ends at E20 while the first is still dividing.
        fill_block(300, 400, 4, 4);
        send_frame();
        k = 0; p = 0; p1 = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (bus.odval) begin
                p++;
                if (k == 0) k = i;
            end
            if (d1_dval) p1++;
            if (i == 18 || i == 19) drive(1'b1, 1'b1, 1'b1, 7, 9);
            else junk();
        end
        check_frame("overrun", k, p, p1);
        chk("overrun.flag", bus.ooverrun, 1);
        chk("overrun.d1_flag", d1_ovr, 1);

        fill_block(600, 700, 5, 4);
        send_frame();
        wait_result(k, p, p1);
        check_frame("after_overrun", k, p, p1);
        chk("after_overrun.flag", bus.ooverrun, 1);

        // Reset lands on E40, in the middle of the Y division.
        fill_block(900, 100, 4, 5);
        send_frame();
        p = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.odval) p++;
            junk();
            if (i == 40) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk_zero("mid_reset");
        mx = 0; my = 0; ax = 0; ay = 0;
`ifdef BLOB_CENTROID_ROI_EN
        rx = 0; ry = 0;
`endif
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.odval || d1_dval) p++;
            junk();
        end
        chk("mid_reset.no_pulse", p, 0);
        fill_block(250, 30, 4, 4);
        send_frame();
        wait_result(k, p, p1);
        check_frame("post_reset", k, p, p1);

        for (int r = 0; r < 12; r++) begin
            hx.delete();
            hy.delete();
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                hx.push_back($urandom_range(0, 2047));
                hy.push_back($urandom_range(0, 1023));
            end
            send_frame();
            wait_result(k, p, p1);
            check_frame($sformatf("rand%0d", r), k, p, p1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
